// File: rtl/crack_pkg.sv
// Shared types for the RC4 key-search controller: top/slot state encodings and index-width helper.
// No logic; imported by crack_slot and multi_crack_ctrl.
package crack_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        SUCCESS = 3'd3,
        FAILURE = 3'd4
    } top_state_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_ACK   = 3'd4
    } slot_state_e;

    // Width of a core index; one extra bit keeps a single-core build at width 1.
    function automatic int CORE_IDX_W(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/crack_slot.sv
// One engine slot: latches a granted key, pulses core_start one cycle after the grant, then acks the result.
// Holds core_ack until the engine drops both valid and invalid; never accepts a grant unless idle.
module crack_slot
    import crack_pkg::*;
#(
    parameter int KEY_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 grant,
    input  logic [KEY_WIDTH-1:0] grant_key,
    input  logic                 core_finish,
    input  logic                 core_valid,
    input  logic                 core_invalid,
    output logic                 core_start,
    output logic [KEY_WIDTH-1:0] core_key,
    output logic                 core_ack,
    output logic                 idle,
    output logic                 result_valid,
    output logic                 result_take,
    output logic [KEY_WIDTH-1:0] result_key
);

    slot_state_e          state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 start_q, start_d;
    logic                 ack_q, ack_d;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        start_d = 1'b0;
        ack_d   = ack_q;
        case (state_q)
            S_IDLE:  if (grant) begin
                         state_d = S_ISSUE;
                         key_d   = grant_key;
                     end
            S_ISSUE: begin
                         state_d = S_WAIT;
                         start_d = 1'b1;
                     end
            S_WAIT:  if (core_finish) state_d = S_CHECK;
            // A finish with neither flag raised parks here until the engine decides.
            S_CHECK: if (core_valid || core_invalid) begin
                         state_d = S_ACK;
                         ack_d   = 1'b1;
                     end
            S_ACK:   if (!core_valid && !core_invalid) begin
                         state_d = S_IDLE;
                         ack_d   = 1'b0;
                     end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            start_q <= start_d;
            ack_q   <= ack_d;
        end
    end

    assign core_start   = start_q;
    assign core_key     = key_q;
    assign core_ack     = ack_q;
    assign result_key   = key_q;
    assign idle         = (state_q == S_IDLE);
    assign result_valid = (state_q == S_CHECK) && core_valid;
    assign result_take  = (state_q == S_CHECK) && (core_valid || core_invalid);

endmodule

// File: rtl/multi_crack_ctrl.sv
// Multi-core RC4 key-search controller; CRACK_PERF_EN adds keys_tested/cycle_count counters.
// First core_start two cycles after start; one key grant per cycle to the lowest idle slot, none once a valid result is seen.
module multi_crack_ctrl
    import crack_pkg::*;
#(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MIN   = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = '1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    input  logic [NUM_CORES-1:0]           core_finish,
    input  logic [NUM_CORES-1:0]           core_valid,
    input  logic [NUM_CORES-1:0]           core_invalid,
    output logic [NUM_CORES-1:0]           core_ack,
    output logic                           busy,
    output logic                           crack_success,
    output logic                           crack_failure,
    output logic [KEY_WIDTH-1:0]           successful_key,
    output logic [CORE_IDX_W(NUM_CORES)-1:0] successful_core,
    output logic [2:0]                     crack_state
`ifdef CRACK_PERF_EN
    ,
    output logic [KEY_WIDTH:0]             keys_tested,
    output logic [31:0]                    cycle_count
`endif
);

    localparam int IDX_W = CORE_IDX_W(NUM_CORES);

    logic [NUM_CORES-1:0] slot_idle, slot_valid, slot_take, grant;
    logic [KEY_WIDTH-1:0] slot_key [NUM_CORES];

    top_state_e           state_q, state_d;
    logic [KEY_WIDTH:0]   next_key_q, next_key_d;
    logic                 succ_q, succ_d, fail_q, fail_d, busy_q, busy_d;
    logic [KEY_WIDTH-1:0] skey_q, skey_d, win_key;
    logic [IDX_W-1:0]     score_q, score_d, win_idx;
    logic                 exhausted, any_valid, all_idle, start_accept;
    int                   gidx;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
        crack_slot #(.KEY_WIDTH(KEY_WIDTH)) u_slot (
            .clk          (clk),
            .reset        (reset),
            .grant        (grant[g]),
            .grant_key    (next_key_q[KEY_WIDTH-1:0]),
            .core_finish  (core_finish[g]),
            .core_valid   (core_valid[g]),
            .core_invalid (core_invalid[g]),
            .core_start   (core_start[g]),
            .core_key     (core_key[g*KEY_WIDTH +: KEY_WIDTH]),
            .core_ack     (core_ack[g]),
            .idle         (slot_idle[g]),
            .result_valid (slot_valid[g]),
            .result_take  (slot_take[g]),
            .result_key   (slot_key[g])
        );
    end

    always_comb begin
        exhausted    = next_key_q > {1'b0, KEY_MAX};
        any_valid    = |slot_valid;
        all_idle     = &slot_idle;
        start_accept = start && (state_q == IDLE || state_q == SUCCESS || state_q == FAILURE);
        win_idx      = '0;
        win_key      = '0;
        gidx         = 0;
        // Descending scans leave the lowest matching index in place.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (slot_valid[i]) begin
                win_idx = IDX_W'(i);
                win_key = slot_key[i];
            end
            if (slot_idle[i]) gidx = i;
        end
        grant = '0;
        if (state_q == RUN && !exhausted && !any_valid && |slot_idle)
            grant = NUM_CORES'(1) << gidx;
    end

    always_comb begin
        state_d    = state_q;
        next_key_d = next_key_q;
        succ_d     = succ_q;
        fail_d     = fail_q;
        skey_d     = skey_q;
        score_d    = score_q;
        if (start_accept) begin
            state_d    = RUN;
            next_key_d = {1'b0, KEY_MIN};
            succ_d     = 1'b0;
            fail_d     = 1'b0;
            skey_d     = '0;
            score_d    = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (any_valid) begin
                        state_d = DRAIN;
                        skey_d  = win_key;
                        score_d = win_idx;
                    end else if (exhausted && all_idle) begin
                        state_d = FAILURE;
                        fail_d  = 1'b1;
                    end
                    if (|grant) next_key_d = next_key_q + (KEY_WIDTH+1)'(1);
                end
                DRAIN: if (all_idle) begin
                    state_d = SUCCESS;
                    succ_d  = 1'b1;
                end
                IDLE, SUCCESS, FAILURE: ;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN) || (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            next_key_q <= {1'b0, KEY_MIN};
            succ_q     <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
            skey_q     <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            next_key_q <= next_key_d;
            succ_q     <= succ_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
            skey_q     <= skey_d;
            score_q    <= score_d;
        end
    end

    assign busy            = busy_q;
    assign crack_success   = succ_q;
    assign crack_failure   = fail_q;
    assign successful_key  = skey_q;
    assign successful_core = score_q;
    assign crack_state     = state_q;

`ifdef CRACK_PERF_EN
    logic [KEY_WIDTH:0] keys_q, keys_d;
    logic [31:0]        cyc_q, cyc_d;

    always_comb begin
        keys_d = keys_q;
        cyc_d  = cyc_q;
        if (start_accept) begin
            keys_d = '0;
            cyc_d  = '0;
        end else if (state_q == RUN || state_q == DRAIN) begin
            for (int i = 0; i < NUM_CORES; i++)
                if (slot_take[i]) keys_d = keys_d + (KEY_WIDTH+1)'(1);
            if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            keys_q <= '0;
            cyc_q  <= '0;
        end else begin
            keys_q <= keys_d;
            cyc_q  <= cyc_d;
        end
    end

    assign keys_tested = keys_q;
    assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_multi_crack_ctrl.sv
// Bench for multi_crack_ctrl: three configurations (4 cores 0..7, 4 cores 0..15, 1 core FFFFFF only)
// driven by behavioural engines; issued keys are checked in order against a queue of expected keys.
module tb_multi_crack_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [2:0] start = '0;

    logic [3:0]  cst0, cst1, cack0, cack1;
    logic [95:0] ckey0, ckey1;
    logic        cst2, cack2;
    logic [23:0] ckey2, skey0, skey1, skey2;
    logic        busy0, busy1, busy2, succ0, succ1, succ2, fail0, fail1, fail2;
    logic [2:0]  score0, score1, state0, state1, state2;
    logic        score2;

    logic [8:0]  e_fin = '0, e_val = '0, e_inv = '0;
    logic [8:0]  e_start, e_ack;
    logic [23:0] e_key [9];

    assign e_start = {cst2, cst1, cst0};
    assign e_ack   = {cack2, cack1, cack0};

    multi_crack_ctrl #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MIN(24'd0), .KEY_MAX(24'd7)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .core_start(cst0), .core_key(ckey0),
        .core_finish(e_fin[3:0]), .core_valid(e_val[3:0]), .core_invalid(e_inv[3:0]),
        .core_ack(cack0), .busy(busy0), .crack_success(succ0), .crack_failure(fail0),
        .successful_key(skey0), .successful_core(score0), .crack_state(state0));

    multi_crack_ctrl #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MIN(24'd0), .KEY_MAX(24'd15)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .core_start(cst1), .core_key(ckey1),
        .core_finish(e_fin[7:4]), .core_valid(e_val[7:4]), .core_invalid(e_inv[7:4]),
        .core_ack(cack1), .busy(busy1), .crack_success(succ1), .crack_failure(fail1),
        .successful_key(skey1), .successful_core(score1), .crack_state(state1));

    multi_crack_ctrl #(.NUM_CORES(1), .KEY_WIDTH(24), .KEY_MIN(24'hFFFFFF), .KEY_MAX(24'hFFFFFF)) dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .core_start(cst2), .core_key(ckey2),
        .core_finish(e_fin[8]), .core_valid(e_val[8]), .core_invalid(e_inv[8]),
        .core_ack(cack2), .busy(busy2), .crack_success(succ2), .crack_failure(fail2),
        .successful_key(skey2), .successful_core(score2), .crack_state(state2));

    // Per-instance views so checks can be indexed by instance number.
    logic [2:0]  st [3];
    logic        sc [3], fl [3], bz [3];
    logic [23:0] sk [3];
    logic [2:0]  sco [3];
    logic [3:0]  cstv [3], ackv [3];
    logic [95:0] ckv [3];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            e_key[i]     = ckey0[i*24 +: 24];
            e_key[i + 4] = ckey1[i*24 +: 24];
        end
        e_key[8] = ckey2;
        st  = '{state0, state1, state2};
        sc  = '{succ0, succ1, succ2};
        fl  = '{fail0, fail1, fail2};
        bz  = '{busy0, busy1, busy2};
        sk  = '{skey0, skey1, skey2};
        sco = '{score0, score1, {2'b00, score2}};
        cstv = '{cst0, cst1, {3'b000, cst2}};
        ackv = '{cack0, cack1, {3'b000, cack2}};
        ckv  = '{ckey0, ckey1, {72'd0, ckey2}};
    end

    int errs = 0, checks = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Engine behaviour shared by all configurations.
    int tgt_a = -1, tgt_b = -1, lat_mode = 0, hold = 0, cur_inst = 0;
    int phase [9], cnt [9], hcnt [9], ekey [9];

    always @(negedge clk) begin
        for (int e = 0; e < 9; e++) begin
            e_fin[e] = 1'b0;
            if (reset) begin
                phase[e] = 0;
                e_val[e] = 1'b0;
                e_inv[e] = 1'b0;
            end else if (e_start[e]) begin
                ekey[e]  = int'(e_key[e]);
                cnt[e]   = (lat_mode == 0) ? 6 : 10 - (e % 4);
                phase[e] = 1;
            end else if (phase[e] == 1) begin
                cnt[e]--;
                if (cnt[e] == 0) begin
                    e_fin[e] = 1'b1;
                    e_val[e] = (ekey[e] == tgt_a) || (ekey[e] == tgt_b);
                    e_inv[e] = !e_val[e];
                    phase[e] = 2;
                end
            end else if (phase[e] == 2) begin
                if (e_ack[e]) begin
                    if (hold > 0 && (e % 4) == 0) begin
                        hcnt[e]  = hold;
                        phase[e] = 3;
                    end else begin
                        e_val[e] = 1'b0;
                        e_inv[e] = 1'b0;
                        phase[e] = 0;
                    end
                end
            end else if (phase[e] == 3) begin
                check("ack_held", {95'd0, e_ack[e]}, 96'd1);
                check("no_regrant", {95'd0, e_start[e]}, 96'd0);
                hcnt[e]--;
                if (hcnt[e] == 0) begin
                    e_val[e] = 1'b0;
                    e_inv[e] = 1'b0;
                    phase[e] = 0;
                end
            end
        end
    end

    // Scoreboard: every core_start of the active instance pops the next expected key.
    int q [$];
    int prev_state = 0, drain_err = 0;

    always @(negedge clk) begin
        if (!reset) begin
            int lo, hi;
            logic any;
            lo  = cur_inst * 4;
            hi  = (cur_inst == 2) ? 8 : lo + 3;
            any = 1'b0;
            for (int e = lo; e <= hi; e++) begin
                if (e_start[e]) begin
                    any = 1'b1;
                    if (q.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL extra_key: got %0h expected none", e_key[e]);
                    end else begin
                        check("issued_key", {72'd0, e_key[e]}, 96'(q.pop_front()));
                    end
                end
            end
            if (any && st[cur_inst] == 3'd2 && prev_state == 2) drain_err++;
            prev_state = int'(st[cur_inst]);
        end
    end

    typedef struct {
        int inst;
        int tgt_a;
        int tgt_b;
        int lat_mode;
        int hold;
        bit exp_succ;
        int exp_key;
        int exp_core;
        bit exp_all;
    } vec_t;

    task automatic load_queue(input int inst);
        q.delete();
        if (inst == 2) q.push_back(24'hFFFFFF);
        else for (int k = 0; k <= (inst == 0 ? 7 : 15); k++) q.push_back(k);
    endtask

    task automatic wait_done(input int inst);
        int n = 0;
        while (!(st[inst] == 3'd3 || st[inst] == 3'd4) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errs++;
            $display("FAIL timeout: state %0d after %0d cycles, required 3 or 4", st[inst], n);
        end
    endtask

    task automatic run_vec(input vec_t v);
        tgt_a = v.tgt_a; tgt_b = v.tgt_b; lat_mode = v.lat_mode; hold = v.hold;
        cur_inst = v.inst;
        load_queue(v.inst);
        drain_err = 0;
        @(negedge clk);
        start[v.inst] = 1'b1;
        @(negedge clk);
        start[v.inst] = 1'b0;
        check("state_run", {93'd0, st[v.inst]}, 96'd1);
        check("busy_run", {95'd0, bz[v.inst]}, 96'd1);
        wait_done(v.inst);
        check("success", {95'd0, sc[v.inst]}, {95'd0, v.exp_succ});
        check("failure", {95'd0, fl[v.inst]}, {95'd0, !v.exp_succ});
        check("busy_done", {95'd0, bz[v.inst]}, 96'd0);
        if (v.exp_succ) begin
            check("win_key", {72'd0, sk[v.inst]}, 96'(v.exp_key));
            check("win_core", {93'd0, sco[v.inst]}, 96'(v.exp_core));
        end
        if (v.exp_all) check("all_keys_issued", 96'(q.size()), 96'd0);
        check("no_grant_in_drain", 96'(drain_err), 96'd0);
    endtask

    vec_t tv [7];

    initial begin
        tv[0] = '{0, -1, -1, 0, 0, 1'b0, 0, 0, 1'b1};
        tv[1] = '{1, 5, -1, 0, 0, 1'b1, 5, 1, 1'b0};
        tv[2] = '{1, 1, 3, 1, 0, 1'b1, 1, 1, 1'b0};
        tv[3] = '{1, 0, -1, 0, 5, 1'b1, 0, 0, 1'b0};
        tv[4] = '{2, 24'hFFFFFF, -1, 0, 0, 1'b1, 24'hFFFFFF, 0, 1'b1};
        tv[5] = '{0, 7, -1, 0, 0, 1'b1, 7, 3, 1'b1};
        tv[6] = '{2, -1, -1, 0, 0, 1'b0, 0, 0, 1'b1};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_state", {93'd0, st[i]}, 96'd0);
            check("rst_flags", {93'd0, bz[i], sc[i], fl[i]}, 96'd0);
            check("rst_outs", {ckv[i] | {68'd0, sk[i], cstv[i]} | {89'd0, sco[i], ackv[i]}}, 96'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tv[i]);

        // Reset mid-search, then restart: KEY_MIN comes back first with the documented latency.
        tgt_a = -1; tgt_b = -1; lat_mode = 0; hold = 0; cur_inst = 1;
        load_queue(1);
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (10) @(negedge clk);
        check("midrun_busy", {95'd0, busy1}, 96'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_state", {93'd0, state1}, 96'd0);
        check("rst_mid_outs", ckey1 | {88'd0, cst1, cack1}, 96'd0);
        check("rst_mid_flags", {93'd0, busy1, succ1, fail1}, 96'd0);
        check("rst_mid_win", {69'd0, skey1, score1}, 96'd0);
        load_queue(1);
        reset = 1'b0;
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        check("lat_t0", {92'd0, cst1}, 96'd0);
        @(negedge clk);
        check("lat_t1", {92'd0, cst1}, 96'd0);
        @(negedge clk);
        check("lat_t2", {92'd0, cst1}, 96'd1);
        check("first_key", {72'd0, ckey1[23:0]}, 96'd0);
        @(negedge clk);
        check("lat_t3", {92'd0, cst1}, 96'd2);
        wait_done(1);
        check("restart_failure", {94'd0, fail1, succ1}, 96'd2);
        check("restart_all_keys", 96'(q.size()), 96'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
